// File: rtl/pipeline_run_controller_if.sv
// Command and pipeline-control bundle between the debug front end and the run controller.
// Optional breakpoint signals appear only when BREAKPOINT_EN is defined.
interface pipeline_run_controller_if #(
    parameter int CNT_WIDTH = 32
);
    // Handshake: a command transfers on a rising clk_in edge where Cmd_Valid and Cmd_Ready
    // are both high; the master holds Cmd_Code stable while Cmd_Valid is high and not yet accepted.
    logic                 Cmd_Valid;
    logic [1:0]           Cmd_Code;
    logic                 Cmd_Ready;
    logic                 Halt_Detected;
    logic                 Pipe_Enable;
    logic                 PC_Enable;
    logic                 Pipe_Flush;
    logic [2:0]           State;
    logic                 Halted;
    logic [CNT_WIDTH-1:0] Cycle_Count;
`ifdef BREAKPOINT_EN
    logic                 Bp_Enable;
    logic [31:0]          Bp_Addr;
    logic [31:0]          IF_PC;

    modport master (
        output Cmd_Valid, Cmd_Code, Halt_Detected, Bp_Enable, Bp_Addr, IF_PC,
        input  Cmd_Ready, Pipe_Enable, PC_Enable, Pipe_Flush, State, Halted, Cycle_Count
    );
    modport slave (
        input  Cmd_Valid, Cmd_Code, Halt_Detected, Bp_Enable, Bp_Addr, IF_PC,
        output Cmd_Ready, Pipe_Enable, PC_Enable, Pipe_Flush, State, Halted, Cycle_Count
    );
`else
    modport master (
        output Cmd_Valid, Cmd_Code, Halt_Detected,
        input  Cmd_Ready, Pipe_Enable, PC_Enable, Pipe_Flush, State, Halted, Cycle_Count
    );
    modport slave (
        input  Cmd_Valid, Cmd_Code, Halt_Detected,
        output Cmd_Ready, Pipe_Enable, PC_Enable, Pipe_Flush, State, Halted, Cycle_Count
    );
`endif
endinterface

// File: rtl/pipeline_run_controller.sv
// Run/step/pause/clear sequencer gating the 5-stage MIPS pipeline, with HALT drain.
// Optional feature macro: BREAKPOINT_EN (PC breakpoint that stops fetch while running).
module pipeline_run_controller #(
    parameter int DRAIN_DEPTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input logic                      clk_in,
    input logic                      Reset,
    pipeline_run_controller_if.slave bus
);
    localparam int DW = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_PAUSE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t               state_q;
    logic                 pipe_en_q;
    logic                 pc_en_q;
    logic                 flush_q;
    logic [DW-1:0]        drain_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic cmd_ready;
    logic accept;
    logic halt_take;
    logic clear_take;
    logic pipe_en_eff;
    logic pc_en_eff;

    assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_HALTED);
    assign accept     = bus.Cmd_Valid && cmd_ready;
    // A HALT seen while fetching discards any command accepted on the same edge.
    assign halt_take  = pc_en_q && bus.Halt_Detected;
    assign clear_take = accept && (bus.Cmd_Code == CMD_CLEAR) && !halt_take;

`ifdef BREAKPOINT_EN
    logic skip_q;
    logic bp_gate;

    // The first cycle after leaving IDLE ignores a match so a stopped breakpoint can be resumed.
    assign bp_gate     = (state_q == S_RUN) && bus.Bp_Enable && (bus.IF_PC == bus.Bp_Addr)
                         && !skip_q && !bus.Halt_Detected;
    assign pipe_en_eff = pipe_en_q && !bp_gate;
    assign pc_en_eff   = pc_en_q && !bp_gate;

    always_ff @(posedge clk_in or negedge Reset) begin
        if (!Reset) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= (state_q == S_IDLE) && accept &&
                      ((bus.Cmd_Code == CMD_RUN) || (bus.Cmd_Code == CMD_STEP));
        end
    end
`else
    assign pipe_en_eff = pipe_en_q;
    assign pc_en_eff   = pc_en_q;
`endif

    assign cnt_d = clear_take ? '0 : (cnt_q + CNT_WIDTH'(pipe_en_eff));

    always_ff @(posedge clk_in or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            pipe_en_q <= 1'b0;
            pc_en_q   <= 1'b0;
            flush_q   <= 1'b0;
            drain_q   <= '0;
            cnt_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            flush_q   <= clear_take;
            pipe_en_q <= 1'b0;
            pc_en_q   <= 1'b0;
            if (halt_take) begin
                state_q   <= S_DRAIN;
                pipe_en_q <= 1'b1;
                drain_q   <= DW'(DRAIN_DEPTH - 1);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                        if (accept && (bus.Cmd_Code == CMD_RUN)) begin
                            state_q   <= S_RUN;
                            pipe_en_q <= 1'b1;
                            pc_en_q   <= 1'b1;
                        end else if (accept && (bus.Cmd_Code == CMD_STEP)) begin
                            state_q   <= S_STEP;
                            pipe_en_q <= 1'b1;
                            pc_en_q   <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (accept && ((bus.Cmd_Code == CMD_CLEAR) ||
                                       (bus.Cmd_Code == CMD_PAUSE))) begin
                            state_q <= S_IDLE;
`ifdef BREAKPOINT_EN
                        end else if (bp_gate) begin
                            state_q <= S_IDLE;
`endif
                        end else begin
                            state_q   <= S_RUN;
                            pipe_en_q <= 1'b1;
                            pc_en_q   <= 1'b1;
                        end
                    end
                    S_STEP: begin
                        state_q <= S_IDLE;
                    end
                    S_DRAIN: begin
                        // Counter was loaded with DRAIN_DEPTH-1, giving DRAIN_DEPTH enabled cycles.
                        if (drain_q == '0) begin
                            state_q <= S_HALTED;
                        end else begin
                            state_q   <= S_DRAIN;
                            pipe_en_q <= 1'b1;
                            drain_q   <= drain_q - DW'(1);
                        end
                    end
                    S_HALTED: begin
                        state_q <= clear_take ? S_IDLE : S_HALTED;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Cmd_Ready   = cmd_ready;
    assign bus.Pipe_Enable = pipe_en_eff;
    assign bus.PC_Enable   = pc_en_eff;
    assign bus.Pipe_Flush  = flush_q;
    assign bus.State       = state_q;
    assign bus.Halted      = (state_q == S_HALTED);
    assign bus.Cycle_Count = cnt_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed scenarios plus random commands for pipeline_run_controller, checked against a
// state-level model; a second 4-bit-counter instance shares the stimulus for wrap checks.
module tb_pipeline_run_controller;
  localparam int DEPTH = 4;
  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_PAUSE = 2'b11;

  logic clk_in = 1'b0;
  logic Reset  = 1'b0;
  int checks   = 0;
  int failures = 0;

  pipeline_run_controller_if #(.CNT_WIDTH(32)) bus ();
  pipeline_run_controller_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus4.Cmd_Valid     = bus.Cmd_Valid;
  assign bus4.Cmd_Code      = bus.Cmd_Code;
  assign bus4.Halt_Detected = bus.Halt_Detected;
`ifdef BREAKPOINT_EN
  assign bus4.Bp_Enable = bus.Bp_Enable;
  assign bus4.Bp_Addr   = bus.Bp_Addr;
  assign bus4.IF_PC     = bus.IF_PC;
`endif

  pipeline_run_controller #(.DRAIN_DEPTH(DEPTH), .CNT_WIDTH(32)) u_dut (
    .clk_in (clk_in),
    .Reset  (Reset),
    .bus    (bus)
  );

  pipeline_run_controller #(.DRAIN_DEPTH(DEPTH), .CNT_WIDTH(4)) u_dut4 (
    .clk_in (clk_in),
    .Reset  (Reset),
    .bus    (bus4)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // reference model: abstract state number plus counts
  int          ms;
  int          mdr;
  logic [31:0] mcnt;
  logic        mflush;
  logic [7:0]  exp_q[$];

  function automatic logic [7:0] pack_exp();
    logic en, fetch, rdy, hlt;
    en    = (ms == 1) || (ms == 2) || (ms == 3);
    fetch = (ms == 1) || (ms == 2);
    rdy   = (ms == 0) || (ms == 1) || (ms == 4);
    hlt   = (ms == 4);
    return {3'(ms), en, fetch, mflush, rdy, hlt};
  endfunction

  task automatic model_reset();
    ms = 0; mdr = 0; mcnt = '0; mflush = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] c, input logic h);
    logic rdy, acc, htake, clr, en;
    int   ns;
    rdy   = (ms == 0) || (ms == 1) || (ms == 4);
    acc   = v && rdy;
    en    = (ms == 1) || (ms == 2) || (ms == 3);
    htake = ((ms == 1) || (ms == 2)) && h;
    clr   = acc && (c == C_CLEAR) && !htake;
    mcnt  = clr ? 32'd0 : mcnt + 32'(en);
    ns    = ms;
    if (htake) begin
      ns = 3; mdr = DEPTH - 1;
    end else begin
      case (ms)
        0: ns = (acc && c == C_RUN) ? 1 : (acc && c == C_STEP) ? 2 : 0;
        1: ns = (acc && (c == C_CLEAR || c == C_PAUSE)) ? 0 : 1;
        2: ns = 0;
        3: if (mdr == 0) ns = 4; else mdr = mdr - 1;
        4: ns = clr ? 0 : 4;
        default: ns = 0;
      endcase
    end
    ms     = ns;
    mflush = clr;
    exp_q.push_back(pack_exp());
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present inputs away from the edge, advance one edge, compare against the model
  task automatic step(input logic v, input logic [1:0] c, input logic h, input string tag);
    logic [7:0] e;
    bus.Cmd_Valid     = v;
    bus.Cmd_Code      = c;
    bus.Halt_Detected = h;
    model_step(v, c, h);
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check({tag, ".outs"}, 64'({bus.State, bus.Pipe_Enable, bus.PC_Enable, bus.Pipe_Flush,
                               bus.Cmd_Ready, bus.Halted}), 64'(e));
    check({tag, ".cnt"}, 64'(bus.Cycle_Count), 64'(mcnt));
    check({tag, ".cnt4"}, 64'(bus4.Cycle_Count), 64'(mcnt[3:0]));
    bus.Cmd_Valid = 1'b0;
  endtask

  initial begin
    bus.Cmd_Valid     = 1'b0;
    bus.Cmd_Code      = C_CLEAR;
    bus.Halt_Detected = 1'b0;
`ifdef BREAKPOINT_EN
    bus.Bp_Enable = 1'b0;
    bus.Bp_Addr   = 32'h0;
    bus.IF_PC     = 32'h0;
`endif
    model_reset();

    // reset state
    #12;
    check("rst.state", 64'(bus.State), 64'd0);
    check("rst.pe", 64'(bus.Pipe_Enable), 64'd0);
    check("rst.pce", 64'(bus.PC_Enable), 64'd0);
    check("rst.flush", 64'(bus.Pipe_Flush), 64'd0);
    check("rst.cnt", 64'(bus.Cycle_Count), 64'd0);
    check("rst.halted", 64'(bus.Halted), 64'd0);
    check("rst.ready", 64'(bus.Cmd_Ready), 64'd1);
    @(negedge clk_in);
    Reset = 1'b1;
    step(1'b0, C_PAUSE, 1'b0, "idle");

    // RUN for 10 enabled cycles then PAUSE
    step(1'b1, C_RUN, 1'b0, "run.acc");
    for (int i = 0; i < 9; i++) step(1'b0, C_RUN, 1'b0, "run.go");
    step(1'b1, C_PAUSE, 1'b0, "run.pause");
    check("run.cnt10", 64'(bus.Cycle_Count), 64'd10);
    check("run.ready", 64'(bus.Cmd_Ready), 64'd1);

    // CLEAR then three STEPs with Cmd_Valid held
    step(1'b1, C_CLEAR, 1'b0, "clr1");
    check("clr1.flush", 64'(bus.Pipe_Flush), 64'd1);
    for (int i = 0; i < 6; i++) step(1'b1, C_STEP, 1'b0, "step");
    check("step.cnt3", 64'(bus.Cycle_Count), 64'd3);

    // HALT at run cycle 5 with PAUSE on the same edge
    step(1'b1, C_CLEAR, 1'b0, "clr2");
    step(1'b1, C_RUN, 1'b0, "halt.run");
    for (int i = 0; i < 4; i++) step(1'b0, C_RUN, 1'b0, "halt.go");
    step(1'b1, C_PAUSE, 1'b1, "halt.hit");
    check("halt.drain", 64'(bus.State), 64'd3);
    for (int i = 0; i < 4; i++) step(1'b0, C_RUN, 1'b0, "drain");
    check("halt.state", 64'(bus.State), 64'd4);
    check("halt.cnt9", 64'(bus.Cycle_Count), 64'd9);

    // HALTED: RUN ignored, CLEAR exits with one flush cycle
    step(1'b1, C_RUN, 1'b0, "hlt.run");
    step(1'b1, C_CLEAR, 1'b0, "hlt.clr");
    check("hlt.flush", 64'(bus.Pipe_Flush), 64'd1);
    check("hlt.cnt0", 64'(bus.Cycle_Count), 64'd0);
    step(1'b0, C_RUN, 1'b0, "hlt.after");
    check("hlt.flush_off", 64'(bus.Pipe_Flush), 64'd0);

    // 17 enabled cycles: 4-bit counter wraps to 1
    step(1'b1, C_RUN, 1'b0, "wrap.run");
    for (int i = 0; i < 16; i++) step(1'b0, C_RUN, 1'b0, "wrap.go");
    step(1'b1, C_PAUSE, 1'b0, "wrap.pause");
    check("wrap.cnt4", 64'(bus4.Cycle_Count), 64'd1);
    check("wrap.cnt32", 64'(bus.Cycle_Count), 64'd17);

    // async reset mid-RUN at count 7
    step(1'b1, C_CLEAR, 1'b0, "ar.clr");
    step(1'b1, C_RUN, 1'b0, "ar.run");
    for (int i = 0; i < 7; i++) step(1'b0, C_RUN, 1'b0, "ar.go");
    check("ar.cnt7", 64'(bus.Cycle_Count), 64'd7);
    #2;
    Reset = 1'b0;
    #1;
    check("ar.state", 64'(bus.State), 64'd0);
    check("ar.pe", 64'(bus.Pipe_Enable), 64'd0);
    check("ar.pce", 64'(bus.PC_Enable), 64'd0);
    check("ar.cnt", 64'(bus.Cycle_Count), 64'd0);
    check("ar.halted", 64'(bus.Halted), 64'd0);
    model_reset();
    @(negedge clk_in);
    Reset = 1'b1;

    // random commands and HALT pulses
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 15) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
Execution sequencer for the 5-stage MIPS pipeline. Gates pipeline advance via a global enable to PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Accepts RUN / STEP / PAUSE / CLEAR commands over a valid/ready handshake from the debug front end. On a HALT instruction it stops fetch and drains in-flight instructions, then parks. Sits beside the MIPS top, driving enables and flush alongside HazardDetection's stall.

Parameters:
DRAIN_DEPTH, 4, pipeline-enabled cycles after HALT detection before entering HALTED (covers ID..WB).
CNT_WIDTH, 32, width of the enabled-cycle counter.

Ports:
clk_in  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Cmd_Valid  input  1  command present.
Cmd_Code  input  2  00 CLEAR, 01 RUN, 10 STEP, 11 PAUSE.
Cmd_Ready  output  1  controller can accept a command this cycle.
Halt_Detected  input  1  HALT opcode currently in IF (from instruction decode).
Pipe_Enable  output  1  all pipeline registers may advance.
PC_Enable  output  1  PC may update (fetch allowed).
Pipe_Flush  output  1  one-cycle flush of all pipeline registers.
State  output  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
Halted  output  1  State==HALTED.
Cycle_Count  output  CNT_WIDTH  cycles with Pipe_Enable=1 since last CLEAR/reset.

Behaviour:
- Reset low (any time, async): State=IDLE, Pipe_Enable=0, PC_Enable=0, Pipe_Flush=0, Cycle_Count=0, drain counter=0, Halted=0.
- Cmd_Ready=1 in IDLE, RUN, HALTED; 0 in STEP and DRAIN. Command accepted on clock edge with Cmd_Valid&Cmd_Ready; outputs reflect new state the next cycle (registered, latency 1).
- IDLE: RUN->RUN; STEP->STEP; CLEAR->IDLE with Pipe_Flush=1 for exactly one cycle and Cycle_Count cleared; PAUSE ignored.
- RUN: Pipe_Enable=PC_Enable=1. PAUSE->IDLE. CLEAR->IDLE with flush. RUN/STEP ignored.
- STEP: Pipe_Enable=PC_Enable=1 for exactly one cycle, then IDLE.
- Halt_Detected sampled only when PC_Enable=1. If high in RUN or STEP: next state DRAIN. Halt_Detected has priority over a simultaneously accepted command (command discarded).
- DRAIN: PC_Enable=0, Pipe_Enable=1 for DRAIN_DEPTH cycles (down-counter loaded DRAIN_DEPTH-1), then HALTED.
- HALTED: Pipe_Enable=PC_Enable=0. Only CLEAR exits (->IDLE with flush); RUN/STEP/PAUSE accepted and ignored.
- Pipe_Flush never asserted outside the cycle after an accepted CLEAR; Pipe_Enable=0 during that flush cycle.
- Cycle_Count increments by 1 on each edge where Pipe_Enable=1; wraps modulo 2^CNT_WIDTH. CLEAR takes priority over increment.
- Undefined State encodings recover to IDLE.

Optional Feature:
BREAKPOINT_EN: adds inputs Bp_Enable (1) and Bp_Addr (32) and input IF_PC (32). In RUN, if Bp_Enable and IF_PC==Bp_Addr, go IDLE with PC_Enable/Pipe_Enable low the same cycle (combinational gate) so the breakpoint instruction is not fetched; next RUN/STEP from IDLE ignores a match for its first cycle. HALT detection beats breakpoint on same cycle. Without macro: ports absent, no breakpoint logic.

Test Plan:
- Reset low mid-RUN at Cycle_Count=7 -> all outputs 0, State=0 immediately, no clock needed.
- RUN accepted, 10 cycles, PAUSE -> Pipe_Enable high 10 cycles after acceptance, Cycle_Count=10, State=IDLE, Cmd_Ready=1.
- Three STEP commands back-to-back with Cmd_Valid held -> Cmd_Ready toggles 1/0, exactly 3 enabled cycles, Cycle_Count=3.
- RUN, Halt_Detected=1 at cycle 5 with PAUSE valid same cycle -> DRAIN, PC_Enable=0, Pipe_Enable=1 for 4 cycles, then State=4, Halted=1, Cycle_Count=9; PAUSE discarded.
- In HALTED send RUN then CLEAR -> RUN ignored; CLEAR gives Pipe_Flush=1 one cycle, Cycle_Count=0, State=IDLE.
- Cycle_Count preloaded via CNT_WIDTH=4, run 17 cycles -> wraps to 1.
